// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - icache/dcache arbiter onto a single L2 request port
module l2_arbiter #(
  parameter int LINE_W     = 256,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  // Counter wide enough to hold STARVE_MAX itself (at least one bit).
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                win_i_q, win_i_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

  logic                d_req;
  logic                grant_i;
  logic                grant_d;

  // Arbitration: dcache wins unless icache has waited through STARVE_MAX dcache grants.
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = i_read & (~d_req | (starve_q == CNT_MAX));
    grant_d = d_req & ~grant_i;
  end

  // State register plus all latched transaction/result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      win_i_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      win_i_q   <= win_i_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state: IDLE waits for any request, BUSY waits for L2, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_read | d_req) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winner's request in IDLE and the L2 line on completion in BUSY.
  always_comb begin
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    win_i_d   = win_i_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == IDLE) begin
      if (grant_i) begin
        addr_d   = i_address;
        write_d  = 1'b0;
        win_i_d  = 1'b1;
        starve_d = '0;
      end else if (grant_d) begin
        addr_d  = d_address;
        wdata_d = d_wdata;
        // A simultaneous read+write from dcache is a writeback.
        write_d = d_write;
        win_i_d = 1'b0;
        if (i_read && (starve_q != CNT_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end
    end
    if ((state_q == BUSY) && mem_resp) begin
      if (win_i_q) begin
        i_rdata_d = mem_rdata;
      end else begin
        d_rdata_d = mem_rdata;
      end
    end
  end

  // Outputs: strobes only in BUSY, one response pulse to the winner in DONE.
  always_comb begin
    mem_read  = (state_q == BUSY) & ~write_q;
    mem_write = (state_q == BUSY) & write_q;
    i_resp    = (state_q == DONE) & win_i_q;
    d_resp    = (state_q == DONE) & ~win_i_q;
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule
